// File: rtl/pool_pkg.sv
// Shared constants, state encoding and helpers for the 2x2 up-sampler.
package pool_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned DN_DEF = 6;
    localparam int unsigned MAX_W  = 64;
    localparam int unsigned CW     = $clog2(MAX_W);

    typedef enum logic {
        ROW0 = 1'b0,
        ROW1 = 1'b1
    } state_t;

    // Index of the last beat in a row; width 0 encodes 64 and maps to 63.
    function automatic logic [CW-1:0] last_idx(input logic [CW-1:0] width);
        return CW'(width - CW'(1));
    endfunction

endpackage

// File: rtl/up_sample_if.sv
// Stream bus between pooled-row producer (master) and up_sample (slave).
interface up_sample_if
    import pool_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned DN = DN_DEF
);

    logic [DN*DW-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CW-1:0]    m_width;
    logic             m_up_en;
    logic [DN*DW-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (
        output m_data, m_valid, m_width, m_up_en, s_ready,
        input  m_ready, s_data, s_valid
    );

    modport slave (
        input  m_data, m_valid, m_width, m_up_en, s_ready,
        output m_ready, s_data, s_valid
    );

endinterface

// File: rtl/up_line_buf.sv
// One pooled row of beats: single write port, combinational read port, no reset.
module up_line_buf
    import pool_pkg::*;
#(
    parameter int unsigned BW = DW_DEF * DN_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [CW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [CW-1:0] raddr,
    output logic [BW-1:0] rdata
);

    logic [BW-1:0] mem [MAX_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/up_sample.sv
// 2x2 nearest-neighbour up-sampler with bypass; define UP_SAMPLE_ZERO_FILL_EN
// for max-unpool style output (duplicates and replayed row become zero).
module up_sample
    import pool_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned DN = DN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    up_sample_if.slave bus
);

    localparam int unsigned BW = DW * DN;

    state_t        state;
    logic          phase;
    logic [CW-1:0] cnt;
    logic [CW-1:0] width_q;
    logic          up_q;
    logic [BW-1:0] s_data_q;
    logic          s_valid_q;

    logic          out_free;
    logic          m_ready_c;
    logic          in_xfer;
    logic          up_now;
    logic          at_last;
    logic [BW-1:0] rd_data;
    logic [BW-1:0] dup_beat;
    logic [BW-1:0] row1_beat;

    assign out_free  = !s_valid_q || bus.s_ready;
    assign m_ready_c = rst_n && (state == ROW0) && !phase && out_free;
    assign in_xfer   = bus.m_valid && m_ready_c;
    // At row start the live enable decides; mid-row the sampled one does.
    assign up_now    = (cnt == '0) ? bus.m_up_en : up_q;
    assign at_last   = (cnt == last_idx(width_q));

`ifdef UP_SAMPLE_ZERO_FILL_EN
    assign dup_beat  = '0;
    assign row1_beat = '0;
`else
    assign dup_beat  = s_data_q;
    assign row1_beat = rd_data;
`endif

    assign bus.m_ready = m_ready_c;
    assign bus.s_data  = s_data_q;
    assign bus.s_valid = s_valid_q;

    up_line_buf #(.BW(BW)) u_line_buf (
        .clk   (clk),
        .we    (in_xfer && up_now),
        .waddr (cnt),
        .wdata (bus.m_data),
        .raddr (cnt),
        .rdata (rd_data)
    );

    // Row sequencer and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ROW0;
            phase     <= 1'b0;
            cnt       <= '0;
            width_q   <= '0;
            up_q      <= 1'b0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
        end else begin
            unique case (state)
                ROW0: begin
                    if (!phase) begin
                        if (in_xfer) begin
                            s_data_q  <= bus.m_data;
                            s_valid_q <= 1'b1;
                            if (cnt == '0) begin
                                width_q <= bus.m_width;
                                up_q    <= bus.m_up_en;
                            end
                            phase <= up_now;
                        end else if (out_free) begin
                            s_valid_q <= 1'b0;
                        end
                    end else if (out_free) begin
                        s_data_q  <= dup_beat;
                        s_valid_q <= 1'b1;
                        phase     <= 1'b0;
                        if (at_last) begin
                            cnt   <= '0;
                            state <= ROW1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ROW1: begin
                    if (out_free) begin
                        s_data_q  <= row1_beat;
                        s_valid_q <= 1'b1;
                        phase     <= !phase;
                        if (phase) begin
                            if (at_last) begin
                                cnt   <= '0;
                                state <= ROW0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
